johnson_decoder: RTL and testbench

- Receive end of the 4-bit, 8-state Johnson count sequence: samples a 4-bit code, decodes it to a 3-bit index, and checks that each sample is the legal successor of the previous one.
- Flags illegal codes and sequence breaks, tracks lock through an acquire/lock state machine, and keeps a saturating error count.
- Sits downstream of the Johnson counter in lab bring-up, either directly or across a board/GPIO link.

---
 rtl/johnson_decoder_if.sv | 24 ++
 rtl/johnson_decoder.sv | 136 +++++++++++++
 tb/tb_johnson_decoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/johnson_decoder_if.sv
// Sample/decode bundle between a Johnson code source and johnson_decoder.
// master drives code samples; slave returns decoded index, status pulses and error count.
interface johnson_decoder_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [3:0]       code;
    logic [2:0]       idx;
    logic             idx_valid;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, code,
        input  idx, idx_valid, illegal, seq_err, locked, err_count
    );

    modport slave (
        input  in_valid, code,
        output idx, idx_valid, illegal, seq_err, locked, err_count
    );
endinterface

// File: rtl/johnson_decoder.sv
// Decodes 4-bit Johnson codes, checks successor order, tracks lock and counts errors.
// Latency 1 cycle, all outputs registered; accepts a sample every cycle, no backpressure.
module johnson_decoder #(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    johnson_decoder_if.slave bus
);
    typedef enum logic [1:0] {UNLOCKED = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [2:0]       prev, prev_nxt;
    logic [2:0]       match_cnt, match_nxt;
    logic [2:0]       miss_cnt, miss_nxt;
    logic [2:0]       idx_q, idx_nxt;
    logic             idx_valid_q, idx_valid_nxt;
    logic             illegal_q, illegal_nxt;
    logic             seq_err_q, seq_err_nxt;
    logic             locked_q, locked_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;

    logic             legal;
    logic [2:0]       dec;
    logic             hit;

    always_comb begin
        legal = 1'b1;
        dec   = 3'd0;
        case (bus.code)
            4'b1111: dec = 3'd0;
            4'b0111: dec = 3'd1;
            4'b0011: dec = 3'd2;
            4'b0001: dec = 3'd3;
            4'b0000: dec = 3'd4;
            4'b1000: dec = 3'd5;
            4'b1100: dec = 3'd6;
            4'b1110: dec = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // 3-bit add wraps 7 -> 0, which is the legal successor of 7
    assign hit = (dec == prev + 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNLOCKED;
            prev        <= 3'd0;
            match_cnt   <= 3'd0;
            miss_cnt    <= 3'd0;
            idx_q       <= 3'd0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state       <= state_nxt;
            prev        <= prev_nxt;
            match_cnt   <= match_nxt;
            miss_cnt    <= miss_nxt;
            idx_q       <= idx_nxt;
            idx_valid_q <= idx_valid_nxt;
            illegal_q   <= illegal_nxt;
            seq_err_q   <= seq_err_nxt;
            locked_q    <= locked_nxt;
            err_q       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        if (bus.in_valid) begin
            if (!legal) begin
                state_nxt = UNLOCKED;
                match_nxt = 3'd0;
                miss_nxt  = 3'd0;
            end else begin
                prev_nxt = dec;
                case (state)
                    UNLOCKED: begin
                        state_nxt = ACQUIRE;
                        match_nxt = 3'd0;
                    end
                    ACQUIRE: begin
                        if (hit) begin
                            match_nxt = match_cnt + 3'd1;
                            if ({1'b0, match_cnt} + 4'd1 == 4'(LOCK_N)) begin
                                state_nxt = LOCKED;
                                miss_nxt  = 3'd0;
                            end
                        end else begin
                            match_nxt = 3'd0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_nxt = 3'd0;
                        end else if ({1'b0, miss_cnt} + 4'd1 == 4'(UNLOCK_N)) begin
                            state_nxt = ACQUIRE;
                            match_nxt = 3'd0;
                            miss_nxt  = 3'd0;
                        end else begin
                            miss_nxt = miss_cnt + 3'd1;
                        end
                    end
                    default: state_nxt = UNLOCKED;
                endcase
            end
        end
    end

    always_comb begin
        idx_valid_nxt = bus.in_valid & legal;
        illegal_nxt   = bus.in_valid & ~legal;
        seq_err_nxt   = bus.in_valid & legal & (state == LOCKED) & ~hit;
        idx_nxt       = idx_valid_nxt ? dec : idx_q;
        locked_nxt    = (state_nxt == LOCKED);
        err_nxt       = err_q;
        if ((illegal_nxt || seq_err_nxt) && (err_q != {ERR_W{1'b1}}))
            err_nxt = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = idx_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.locked    = locked_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Directed Johnson-code vectors; expected outputs are queued at issue and checked by a monitor.
module tb_johnson_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    johnson_decoder_if #(.ERR_W(8)) jif ();
    johnson_decoder_if #(.ERR_W(2)) sif ();

    assign sif.in_valid = jif.in_valid;
    assign sif.code     = jif.code;

    johnson_decoder #(.LOCK_N(3), .UNLOCK_N(2), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (jif.slave)
    );

    johnson_decoder #(.LOCK_N(3), .UNLOCK_N(2), .ERR_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    typedef struct {
        int idx;
        int iv;
        int ill;
        int se;
        int lk;
        int err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   nvec  = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL vec%0d %s: got %0d expected %0d", nvec, name, act, want);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [3:0] c,
                        input int idx, input int iv, input int ill,
                        input int se, input int lk, input int err);
        exp_t e;
        @(negedge clk);
        rst          = r;
        jif.in_valid = v;
        jif.code     = c;
        e.idx = idx; e.iv = iv; e.ill = ill; e.se = se; e.lk = lk; e.err = err;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("idx",       int'(jif.idx),       e.idx);
                chk("idx_valid", int'(jif.idx_valid), e.iv);
                chk("illegal",   int'(jif.illegal),   e.ill);
                chk("seq_err",   int'(jif.seq_err),   e.se);
                chk("locked",    int'(jif.locked),    e.lk);
                chk("err_count", int'(jif.err_count), e.err);
                chk("sat_err_count", int'(sif.err_count), (e.err > 3) ? 3 : e.err);
                nvec++;
            end
        end
    end

    initial begin
        int w;
        jif.in_valid = 1'b0;
        jif.code     = 4'b0000;
        // reset, then clean acquire: locked on the 4th sample
        step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1111, 0, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0111, 1, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 2, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0001, 3, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0000, 4, 1, 0, 0, 1, 0);
        // wrap-around 7 -> 0 while locked
        step(0, 1, 4'b1000, 5, 1, 0, 0, 1, 0);
        step(0, 1, 4'b1100, 6, 1, 0, 0, 1, 0);
        step(0, 1, 4'b1110, 7, 1, 0, 0, 1, 0);
        step(0, 1, 4'b1111, 0, 1, 0, 0, 1, 0);
        step(0, 1, 4'b0111, 1, 1, 0, 0, 1, 0);
        // illegal code drops lock, idx holds; next legal code starts acquiring
        step(0, 1, 4'b0101, 1, 0, 1, 0, 0, 1);
        step(0, 1, 4'b0011, 2, 1, 0, 0, 0, 1);
        // gapped sequence re-acquires lock
        step(0, 0, 4'b1010, 2, 0, 0, 0, 0, 1);
        step(0, 1, 4'b0001, 3, 1, 0, 0, 0, 1);
        step(0, 0, 4'b0000, 3, 0, 0, 0, 0, 1);
        step(0, 1, 4'b0000, 4, 1, 0, 0, 0, 1);
        step(0, 0, 4'b1111, 4, 0, 0, 0, 0, 1);
        step(0, 1, 4'b1000, 5, 1, 0, 0, 1, 1);
        // skip then correct keeps lock; skip then repeat loses it
        step(0, 1, 4'b1100, 6, 1, 0, 0, 1, 1);
        step(0, 1, 4'b1111, 0, 1, 0, 1, 1, 2);
        step(0, 1, 4'b0111, 1, 1, 0, 0, 1, 2);
        step(0, 1, 4'b0000, 4, 1, 0, 1, 1, 3);
        step(0, 1, 4'b0000, 4, 1, 0, 1, 0, 4);
        // mismatch in ACQUIRE restarts the match count silently
        step(0, 1, 4'b1000, 5, 1, 0, 0, 0, 4);
        step(0, 1, 4'b1000, 5, 1, 0, 0, 0, 4);
        step(0, 1, 4'b1100, 6, 1, 0, 0, 0, 4);
        step(0, 1, 4'b1110, 7, 1, 0, 0, 0, 4);
        step(0, 1, 4'b1111, 0, 1, 0, 0, 1, 4);
        // remaining illegal codes, narrow counter saturates at 3
        step(0, 1, 4'b0010, 0, 0, 1, 0, 0, 5);
        step(0, 1, 4'b0100, 0, 0, 1, 0, 0, 6);
        step(0, 1, 4'b0110, 0, 0, 1, 0, 0, 7);
        step(0, 1, 4'b1001, 0, 0, 1, 0, 0, 8);
        step(0, 1, 4'b1010, 0, 0, 1, 0, 0, 9);
        step(0, 1, 4'b1011, 0, 0, 1, 0, 0, 10);
        step(0, 1, 4'b1101, 0, 0, 1, 0, 0, 11);
        // relock, then reset with an illegal sample present
        step(0, 1, 4'b0111, 1, 1, 0, 0, 0, 11);
        step(0, 1, 4'b0011, 2, 1, 0, 0, 0, 11);
        step(0, 1, 4'b0001, 3, 1, 0, 0, 0, 11);
        step(0, 1, 4'b0000, 4, 1, 0, 0, 1, 11);
        step(1, 1, 4'b0101, 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 2, 1, 0, 0, 0, 0);
        step(0, 0, 4'b0000, 2, 0, 0, 0, 0, 0);

        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #2;
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
